// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioner (button_pulse_bank).
// Defaults assume a 100 MHz clock.
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_HOLD_CYCLES     = 50000000;
  localparam int DEF_REPEAT_CYCLES   = 10000000;

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, press/release edge pulses.
// Optional hold-to-repeat press pulses when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic press_nxt
);

  localparam int                CNT_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             level_d;
  logic             rise;
  logic             rel_nxt;

  assign rise    = btn_level & ~level_d;
  assign rel_nxt = level_d & ~btn_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      level_d     <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      // Any agreement with the current level restarts the qualification window.
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        btn_level <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d     <= btn_level;
      btn_press   <= press_nxt;
      btn_release <= rel_nxt;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int                HCNT_W    = cnt_w(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'(REPEAT_CYCLES - 1);

  logic [HCNT_W-1:0] hcnt;
  logic              rep_phase;
  logic              rep_fire;

  // Gating with the pre-edge level means a falling level can never produce a repeat
  // in the same cycle as its release pulse.
  assign rep_fire  = btn_level & (hcnt == (rep_phase ? REP_LAST : HOLD_LAST));
  assign press_nxt = rise | rep_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (!btn_level) begin
      hcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      hcnt      <= '0;
      rep_phase <= 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end
`else
  assign press_nxt = rise;
`endif

endmodule

// File: rtl/button_pulse_bank.sv
// N-channel push-button conditioner: clean levels plus one-cycle press/release pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_pulse_bank
  import btn_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            any_press
);

  logic [N_CH-1:0] press_nxt;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in[gi]),
      .btn_level  (btn_level[gi]),
      .btn_press  (btn_press[gi]),
      .btn_release(btn_release[gi]),
      .press_nxt  (press_nxt[gi])
    );
  end

  // Registered from the same next-state terms so it lines up with btn_press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_nxt;
    end
  end

endmodule
